fpu_seq_ctrl: RTL and testbench
===============================

# fpu_seq_ctrl

Sequencing controller for the multi-cycle single-precision FP unit in the single-cycle ARM core. It accepts one decoded FP data-processing instruction at a time, latches operands and destination, starts the FP unit, and stalls the core for the unit's fixed latency. It then writes the result back to the FP register file and releases the core. It sits between the instruction decoder and conditional logic on one side, and the FP unit and FP register-file write port on the other.

## Interface
- ADD_LAT, 3, cycles the FP unit needs for add (FPUOp=0); must be ≥1
- MUL_LAT, 4, cycles the FP unit needs for multiply (FPUOp=1); must be ≥1
- CNT_W, 3, latency counter width; must hold max(ADD_LAT,MUL_LAT)-1

- CLK  in  1  single clock; all state changes on rising edge
- RESETn  in  1  asynchronous, active-low reset
- FPUIssue  in  1  FP instruction present and condition passed (decoder FPUW & CondEx)
- FPUOp  in  1  0 = add, 1 = multiply (decoder FPUcontrol)
- FPRd  in  4  destination FP register S0–S15
- FPOpA, FPOpB  in  32  operands read from the FP register file
- FPUResult  in  32  FP unit result
- FPUStart  out  1  one-cycle start pulse to the FP unit
- FPUOpQ  out  1  latched op to the FP unit
- FPUA, FPUB  out  32  latched operands, stable from FPUStart until WB
- Stall  out  1  hold PC and suppress core register/memory writes
- Busy  out  1  high in EXEC or WB
- FPWE  out  1  FP register-file write enable
- FPWA  out  4  FP write address
- FPWD  out  32  FP write data

## Operation
- FSM states: IDLE, EXEC, WB. Reset and default state is IDLE.
- IDLE:
  - Stall = FPUIssue (combinational).
  - On an edge with FPUIssue=1: latch FPUOpQ←FPUOp, FPWA←FPRd, FPUA←FPOpA, FPUB←FPOpB.
  - On that same edge: set cnt←(FPUOp ? MUL_LAT : ADD_LAT)−1, set the registered FPUStart←1, and go to EXEC.
- EXEC:
  - Stall=1 and Busy=1.
  - FPUStart is high only in the first EXEC cycle.
  - When cnt≠0, decrement cnt each cycle.
  - When cnt==0, on that edge: FPWD←FPUResult and go to WB.
  - Inputs FPUIssue, FPUOp, FPRd, FPOpA and FPOpB are ignored in EXEC.
- WB:
  - Stall=0, FPWE=1, Busy=1.
  - The core's PC advances at the end of this cycle.
  - FPUIssue seen in WB belongs to the instruction just completed and is ignored.
  - Always return to IDLE.
- Outputs FPWE, Busy and Stall are decoded combinationally from state (plus FPUIssue in IDLE). All other outputs are registers.
- Latency 1 is legal: EXEC lasts one cycle (cnt starts at 0).
- Operand latches and FPWD hold their value outside their update edges.
- Reset values, asserted asynchronously: state=IDLE, cnt=0, FPUStart=0, FPUOpQ=0, FPUA=FPUB=0, FPWA=0, FPWD=0. FPWE=0, Busy=0, and Stall follows FPUIssue.
- Reset mid-EXEC or mid-WB: the operation is abandoned and no FPWE pulse is produced, even if the cycle after reset release would have been WB.

## Timing
- Cycle numbering for one instruction:
  - Cycle 0: issue in IDLE.
  - Cycles 1..LAT: EXEC.
  - Cycle LAT+1: WB.
- Occupancy is LAT+2 cycles per FP instruction. Stall is high for LAT+1 cycles (cycles 0..LAT).
- FPUStart is high in cycle 1.
- FPUResult must be valid in cycle LAT, i.e. LAT−1 edges after the FPUStart cycle. It is sampled at the end of cycle LAT.
- FPWE, FPWA and FPWD are all valid together in cycle LAT+1.
- Back-to-back FP instructions: the next issue is accepted in the IDLE cycle immediately after WB. There are no bubble cycles beyond the WB cycle.
- Non-FP instructions with FPUIssue=0 in IDLE see Stall=0 and incur zero overhead.

## Test plan
- Add: FPUIssue=1, FPUOp=0, FPRd=5, FPOpA=0x3F800000, FPOpB=0x40000000, with the model returning 0x40400000 in cycle 3 → Stall high cycles 0–3, FPUStart cycle 1 only, FPWE=1/FPWA=5/FPWD=0x40400000 in cycle 4, Stall=0 in cycle 4.
- Multiply: FPUOp=1, FPRd=15, model result 0x40C00000 in cycle 4 → Stall high cycles 0–4, single FPWE in cycle 5 with FPWA=15, FPUOpQ=1 throughout EXEC.
- Input churn and WB re-issue: change FPOpA/FPRd every cycle during EXEC and hold FPUIssue=1 through WB → FPUA and FPWA keep the cycle-0 values, exactly one FPWE pulse, IDLE after WB.
- Back-to-back: add followed immediately by multiply → the second FPUStart occurs 2 cycles after the first FPWE, giving two FPWE pulses 6 cycles apart (LAT_mul+2).
- Reset mid-operation: assert RESETn=0 in cycle 2 of a multiply, release in cycle 3 with FPUIssue=0 → all outputs reset immediately, no FPWE, Busy=0, and the next issue completes normally.
- Latency 1: ADD_LAT=1 build → EXEC is 1 cycle, FPUStart and the result sample both occur in cycle 1, FPWE in cycle 2.

Source files
------------

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl
//
// Sequencing controller for the multi-cycle single-precision FP unit. It
// accepts one decoded FP data-processing instruction at a time and latches
// its operands, op and destination. It then pulses a start to the FP unit
// and stalls the core for the unit's fixed latency. Finally it writes the
// sampled result to the FP register file and releases the core.
//
// State table
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no FP op in flight; Stall mirrors FPUIssue, issue accepted
//   EXEC   | FP unit running; latency down-counter active; inputs ignored
//   WB     | FPWE asserted for one cycle; core released; issue ignored
//
// Ports
//   CLK        in   clock, all state changes on rising edge
//   RESETn     in   asynchronous active-low reset
//   FPUIssue   in   FP instruction present and condition passed
//   FPUOp      in   0 = add, 1 = multiply
//   FPRd       in   destination FP register S0-S15
//   FPOpA/B    in   operands from the FP register file
//   FPUResult  in   FP unit result, sampled at the end of the last EXEC cycle
//   FPUStart   out  one-cycle start pulse (first EXEC cycle)
//   FPUOpQ     out  latched op
//   FPUA/FPUB  out  latched operands
//   Stall      out  hold PC, suppress core writes
//   Busy       out  high in EXEC or WB
//   FPWE       out  FP register-file write enable
//   FPWA       out  FP write address
//   FPWD       out  FP write data

module fpu_seq_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        FPUIssue,
    input  logic        FPUOp,
    input  logic [3:0]  FPRd,
    input  logic [31:0] FPOpA,
    input  logic [31:0] FPOpB,
    input  logic [31:0] FPUResult,
    output logic        FPUStart,
    output logic        FPUOpQ,
    output logic [31:0] FPUA,
    output logic [31:0] FPUB,
    output logic        Stall,
    output logic        Busy,
    output logic        FPWE,
    output logic [3:0]  FPWA,
    output logic [31:0] FPWD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Terminal-count loads: the counter reaches zero in the last EXEC cycle.
    localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              opq_q, opq_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [3:0]        wa_q, wa_d;
    logic [31:0]       wd_q, wd_d;

    logic              issue_ok;
    logic              cnt_done;

    assign issue_ok = (state_q == S_IDLE) && FPUIssue;
    assign cnt_done = (cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (FPUIssue) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // Issue seen here belongs to the instruction just retired.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (combinational outputs only)
    // ------------------------------------------------------------------
    always_comb begin
        Stall = 1'b0;
        Busy  = 1'b0;
        FPWE  = 1'b0;
        case (state_q)
            S_IDLE: begin
                Stall = FPUIssue;
            end
            S_EXEC: begin
                Stall = 1'b1;
                Busy  = 1'b1;
            end
            S_WB: begin
                Busy  = 1'b1;
                FPWE  = 1'b1;
            end
            default: begin
                Stall = 1'b0;
                Busy  = 1'b0;
                FPWE  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: latches, latency counter, start pulse
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        start_d = 1'b0;
        opq_d   = opq_q;
        a_d     = a_q;
        b_d     = b_q;
        wa_d    = wa_q;
        wd_d    = wd_q;

        if (issue_ok) begin
            cnt_d   = FPUOp ? MUL_CNT : ADD_CNT;
            start_d = 1'b1;
            opq_d   = FPUOp;
            a_d     = FPOpA;
            b_d     = FPOpB;
            wa_d    = FPRd;
        end else if (state_q == S_EXEC) begin
            if (cnt_done) begin
                wd_d = FPUResult;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
            opq_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= start_d;
            opq_q   <= opq_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign FPUStart = start_q;
    assign FPUOpQ   = opq_q;
    assign FPUA     = a_q;
    assign FPUB     = b_q;
    assign FPWA     = wa_q;
    assign FPWD     = wd_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Testbench for fpu_seq_ctrl: directed per-cycle vector table, hand-written
// multi-cycle sequences, and a randomized run checked every cycle against a
// timeline reference model (cycles elapsed since issue).

module tb_fpu_seq_ctrl;

    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;

    logic        CLK;
    logic        RESETn;
    logic        FPUIssue;
    logic        FPUOp;
    logic [3:0]  FPRd;
    logic [31:0] FPOpA;
    logic [31:0] FPOpB;
    logic [31:0] FPUResult;

    logic        FPUStart, FPUOpQ, Stall, Busy, FPWE;
    logic [31:0] FPUA, FPUB, FPWD;
    logic [3:0]  FPWA;

    logic        FPUStart1, FPUOpQ1, Stall1, Busy1, FPWE1;
    logic [31:0] FPUA1, FPUB1, FPWD1;
    logic [3:0]  FPWA1;

    fpu_seq_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .CLK(CLK), .RESETn(RESETn), .FPUIssue(FPUIssue), .FPUOp(FPUOp),
        .FPRd(FPRd), .FPOpA(FPOpA), .FPOpB(FPOpB), .FPUResult(FPUResult),
        .FPUStart(FPUStart), .FPUOpQ(FPUOpQ), .FPUA(FPUA), .FPUB(FPUB),
        .Stall(Stall), .Busy(Busy), .FPWE(FPWE), .FPWA(FPWA), .FPWD(FPWD)
    );

    fpu_seq_ctrl #(.ADD_LAT(1), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut1 (
        .CLK(CLK), .RESETn(RESETn), .FPUIssue(FPUIssue), .FPUOp(FPUOp),
        .FPRd(FPRd), .FPOpA(FPOpA), .FPOpB(FPOpB), .FPUResult(FPUResult),
        .FPUStart(FPUStart1), .FPUOpQ(FPUOpQ1), .FPUA(FPUA1), .FPUB(FPUB1),
        .Stall(Stall1), .Busy(Busy1), .FPWE(FPWE1), .FPWA(FPWA1), .FPWD(FPWD1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge CLK);
    endtask

    task automatic to_next();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iss, input logic op, input logic [3:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        FPUIssue  = iss;
        FPUOp     = op;
        FPRd      = rd;
        FPOpA     = a;
        FPOpB     = b;
        FPUResult = res;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
            to_next();
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one instruction in flight, tracked by the number of
    // cycles elapsed since its issue cycle (k). EXEC is k=1..lat, WB is
    // k=lat+1. Checked at every negedge while m_en is set.
    // ------------------------------------------------------------------
    logic        m_en;
    bit          m_act;
    int          m_k, m_lat;
    logic        m_opq;
    logic [3:0]  m_wa;
    logic [31:0] m_a, m_b, m_wd;
    logic        e_stall, e_busy, e_we, e_start;

    always @(negedge CLK) begin
        if (m_en) begin
            if (!RESETn) begin
                m_act = 0; m_k = 0; m_lat = 0;
                m_opq = 1'b0; m_wa = 4'd0; m_a = 32'd0; m_b = 32'd0; m_wd = 32'd0;
            end
            e_busy  = m_act;
            e_we    = m_act && (m_k == m_lat + 1);
            e_stall = m_act ? (m_k <= m_lat) : FPUIssue;
            e_start = m_act && (m_k == 1);
            chk("mdl_stall", 32'(Stall),    32'(e_stall));
            chk("mdl_busy",  32'(Busy),     32'(e_busy));
            chk("mdl_fpwe",  32'(FPWE),     32'(e_we));
            chk("mdl_start", 32'(FPUStart), 32'(e_start));
            chk("mdl_opq",   32'(FPUOpQ),   32'(m_opq));
            chk("mdl_fpua",  FPUA,          m_a);
            chk("mdl_fpub",  FPUB,          m_b);
            chk("mdl_fpwa",  32'(FPWA),     32'(m_wa));
            chk("mdl_fpwd",  FPWD,          m_wd);
            if (RESETn) begin
                if (!m_act) begin
                    if (FPUIssue) begin
                        m_act = 1; m_k = 1;
                        m_lat = FPUOp ? MUL_LAT : ADD_LAT;
                        m_opq = FPUOp; m_wa = FPRd; m_a = FPOpA; m_b = FPOpB;
                    end
                end else begin
                    if (m_k == m_lat) m_wd = FPUResult;
                    if (m_k == m_lat + 1) m_act = 0;
                    else m_k++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed per-cycle vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic        iss;
        logic        op;
        logic [3:0]  rd;
        logic [31:0] a, b, res;
        logic        stall, start, busy, we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        opq;
        logic [31:0] ea;
    } vec_t;

    vec_t vt[13];

    int we_cnt, we1, we2, st1, st2;

    initial begin
        m_en   = 1'b1;
        RESETn = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);

        // add: 1.0 + 2.0 = 3.0 into S5
        vt[0]  = '{1'b1, 1'b0, 4'd5,  32'h3F800000, 32'h40000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  32'h0,        1'b0, 32'h3F800000};
        vt[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,        1'b0, 32'h3F800000};
        vt[3]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h40400000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,        1'b0, 32'h3F800000};
        vt[4]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  32'h40400000, 1'b0, 32'h3F800000};
        vt[5]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0};
        // multiply: 2.0 * 3.0 = 6.0 into S15
        vt[6]  = '{1'b1, 1'b1, 4'd15, 32'h40000000, 32'h40400000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h11111111, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  32'h0,        1'b1, 32'h40000000};
        vt[8]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,        1'b1, 32'h40000000};
        vt[9]  = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,        1'b1, 32'h40000000};
        vt[10] = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h40C00000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,        1'b1, 32'h40000000};
        vt[11] = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 32'h40C00000, 1'b1, 32'h40000000};
        vt[12] = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 32'h0};

        // reset state
        to_neg();
        chk("rst_busy",  32'(Busy),     32'd0);
        chk("rst_fpwe",  32'(FPWE),     32'd0);
        chk("rst_stall", 32'(Stall),    32'd0);
        chk("rst_start", 32'(FPUStart), 32'd0);
        FPUIssue = 1'b1;
        #1;
        chk("rst_stall_follows_issue", 32'(Stall), 32'd1);
        FPUIssue = 1'b0;
        @(posedge CLK);
        #1;
        RESETn = 1'b1;

        // table
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].iss, vt[i].op, vt[i].rd, vt[i].a, vt[i].b, vt[i].res);
            to_neg();
            chk($sformatf("vec%0d_stall", i), 32'(Stall),    32'(vt[i].stall));
            chk($sformatf("vec%0d_start", i), 32'(FPUStart), 32'(vt[i].start));
            chk($sformatf("vec%0d_busy", i),  32'(Busy),     32'(vt[i].busy));
            chk($sformatf("vec%0d_fpwe", i),  32'(FPWE),     32'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("vec%0d_fpwa", i), 32'(FPWA), 32'(vt[i].wa));
                chk($sformatf("vec%0d_fpwd", i), FPWD,      vt[i].wd);
            end
            if (vt[i].busy && !vt[i].we) begin
                chk($sformatf("vec%0d_opq", i),  32'(FPUOpQ), 32'(vt[i].opq));
                chk($sformatf("vec%0d_fpua", i), FPUA,        vt[i].ea);
            end
            to_next();
        end

        // input churn during EXEC, FPUIssue held through WB
        idle_cycles(6);
        we_cnt = 0;
        for (int c = 0; c <= ADD_LAT + 2; c++) begin
            if (c == 0)
                drive(1'b1, 1'b0, 4'd3, 32'h11111111, 32'h22222222, $urandom);
            else if (c <= ADD_LAT + 1)
                drive(1'b1, 1'($urandom), 4'(c + 6), $urandom, $urandom, $urandom);
            else
                drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
            to_neg();
            if (FPWE) we_cnt++;
            if (c >= 1 && c <= ADD_LAT)
                chk($sformatf("churn_fpua_c%0d", c), FPUA, 32'h11111111);
            if (c == ADD_LAT + 1) begin
                chk("churn_fpwe_wb", 32'(FPWE), 32'd1);
                chk("churn_fpwa_wb", 32'(FPWA), 32'd3);
            end
            if (c == ADD_LAT + 2) begin
                chk("churn_idle_busy",  32'(Busy),  32'd0);
                chk("churn_idle_stall", 32'(Stall), 32'd0);
            end
            to_next();
        end
        chk("churn_fpwe_count", 32'(we_cnt), 32'd1);

        // back-to-back add then multiply
        idle_cycles(6);
        we_cnt = 0; we1 = -1; we2 = -1; st1 = -1; st2 = -1;
        for (int c = 0; c < 14; c++) begin
            if (c == 0)
                drive(1'b1, 1'b0, 4'd1, $urandom, $urandom, $urandom);
            else if (c == ADD_LAT + 1 || c == ADD_LAT + 2)
                drive(1'b1, 1'b1, 4'd2, $urandom, $urandom, $urandom);
            else
                drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
            to_neg();
            if (FPWE) begin
                we_cnt++;
                if (we1 < 0) we1 = c; else we2 = c;
            end
            if (FPUStart) begin
                if (st1 < 0) st1 = c; else st2 = c;
            end
            to_next();
        end
        chk("b2b_fpwe_count",  32'(we_cnt),    32'd2);
        chk("b2b_first_start", 32'(st1),       32'd1);
        chk("b2b_first_fpwe",  32'(we1),       32'(ADD_LAT + 1));
        chk("b2b_start2_gap",  32'(st2 - we1), 32'd2);
        chk("b2b_fpwe_gap",    32'(we2 - we1), 32'(MUL_LAT + 2));

        // reset mid-multiply
        idle_cycles(6);
        drive(1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 32'h0BADF00D, $urandom);
        to_next();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
        to_next();
        RESETn = 1'b0;
        to_neg();
        chk("rmid_busy",  32'(Busy),     32'd0);
        chk("rmid_stall", 32'(Stall),    32'd0);
        chk("rmid_start", 32'(FPUStart), 32'd0);
        chk("rmid_opq",   32'(FPUOpQ),   32'd0);
        chk("rmid_fpua",  FPUA,          32'd0);
        chk("rmid_fpwa",  32'(FPWA),     32'd0);
        to_next();
        RESETn = 1'b1;
        we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            to_neg();
            if (FPWE || Busy) we_cnt++;
            to_next();
        end
        chk("rmid_no_fpwe_busy", 32'(we_cnt), 32'd0);
        drive(1'b1, 1'b0, 4'd9, 32'h3F800000, 32'h3F800000, $urandom);
        we1 = -1;
        for (int c = 0; c < 10; c++) begin
            to_neg();
            if (FPWE && we1 < 0) begin
                we1 = c;
                chk("rmid_after_fpwa", 32'(FPWA), 32'd9);
            end
            to_next();
            drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, $urandom);
        end
        chk("rmid_after_fpwe_cycle", 32'(we1), 32'(ADD_LAT + 1));

        // latency-1 build
        idle_cycles(6);
        drive(1'b1, 1'b0, 4'd11, 32'h40800000, 32'h40A00000, 32'h0);
        to_neg();
        chk("lat1_c0_stall", 32'(Stall1), 32'd1);
        to_next();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hAAAA5555);
        to_neg();
        chk("lat1_c1_start", 32'(FPUStart1), 32'd1);
        chk("lat1_c1_stall", 32'(Stall1),    32'd1);
        chk("lat1_c1_busy",  32'(Busy1),     32'd1);
        chk("lat1_c1_fpwe",  32'(FPWE1),     32'd0);
        to_next();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h0);
        to_neg();
        chk("lat1_c2_fpwe",  32'(FPWE1),  32'd1);
        chk("lat1_c2_fpwa",  32'(FPWA1),  32'd11);
        chk("lat1_c2_fpwd",  FPWD1,       32'hAAAA5555);
        chk("lat1_c2_stall", 32'(Stall1), 32'd0);
        to_next();
        to_neg();
        chk("lat1_c3_busy",  32'(Busy1),  32'd0);
        to_next();

        // randomized run against the model, with occasional resets
        idle_cycles(6);
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom),
                  $urandom, $urandom, $urandom);
            RESETn = ($urandom_range(0, 49) != 0);
            to_next();
        end
        RESETn = 1'b1;
        idle_cycles(8);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
